col_transpose_buf: RTL and testbench
====================================

COL_TRANSPOSE_BUF -- requirements
Module: col_transpose_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: source pixel width; element width EW = DATA_WIDTH+4.
REQ-002 SHALL have parameter N, default 16: elements per vector and vectors per block; must be a power of 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_vld, input, 1 bit: upstream column vector valid; driven by the matrix_cal_top tmp_col output.
REQ-006 SHALL have port in_rdy, output, 1 bit: this block can accept a vector.
REQ-007 SHALL have port in_data, input, EW*N bits: element j occupies bits [EW*(j+1)-1 : EW*j], two's complement.
REQ-008 SHALL have port out_vld, output, 1 bit: transposed vector valid.
REQ-009 SHALL have port out_rdy, input, 1 bit: downstream ready.
REQ-010 SHALL have port out_data, output, EW*N bits: same element packing as in_data.

Function
REQ-011 SHALL treat a transfer as occurring on a rising edge where vld and rdy are both 1, on either port.
REQ-012 SHALL contain two banks (ping-pong), each holding N vectors of N elements of EW bits.
REQ-013 SHALL keep per-bank full flags full[1:0], a write bank select wb, a write count wc (log2 N bits), a read bank select rb and a read count rc (log2 N bits).
REQ-014 SHALL drive in_rdy = !full[wb] from registered state only, with no combinational path from out_rdy or in_vld.
REQ-015 SHALL, on an input transfer, store in_data as vector wc of bank wb and increment wc.
REQ-016 SHALL, on the input transfer with wc = N-1, set full[wb], toggle wb and wrap wc to 0.
REQ-017 SHALL drive out_vld = full[rb].
REQ-018 SHALL drive out_data element i = element rc of stored vector i of bank rb when out_vld = 1, and all zeros when out_vld = 0.
REQ-019 SHALL, on an output transfer, increment rc.
REQ-020 SHALL, on the output transfer with rc = N-1, clear full[rb], toggle rb and wrap rc to 0.
REQ-021 SHALL hold out_data and out_vld stable while out_vld = 1 and out_rdy = 0.
REQ-022 SHALL ignore in_data when in_vld = 0 or in_rdy = 0: no storage write and no counter change.
REQ-023 SHALL handle a simultaneous set of full[wb] and clear of full[rb] in one cycle, with both taking effect; they always address different banks.
REQ-024 SHALL assert out_vld for the first output vector exactly 1 cycle after the N-th input transfer of a block.
REQ-025 SHALL, with in_vld and out_rdy held at 1, sustain one transfer per cycle on both ports with no bubbles between blocks.
REQ-026 SHALL deassert in_rdy, when both banks are full, on the cycle after the filling transfer, and reassert it on the cycle after the N-th output transfer of the older bank.
REQ-027 SHALL pass values through unchanged: no arithmetic, rounding or saturation, width EW in and out.

Reset
REQ-028 SHALL, while rst = 1, force full = 2'b00, wb = 0, rb = 0, wc = 0 and rc = 0.
REQ-029 SHALL give reset output values in_rdy = 1, out_vld = 0 and out_data = 0.
REQ-030 SHALL NOT require bank storage to be reset.
REQ-031 SHALL, on rst asserted mid-block, discard any partial or full block; after release the first accepted vector becomes vector 0 of bank 0.

Verification
REQ-032 SHALL verify single-block transpose: input vector v element k = 16*v+k, out_rdy = 1 -> 16 outputs, output r element i = 16*i+r; out_vld rises 1 cycle after the 16th accept.
REQ-033 SHALL verify back-to-back throughput: 4 blocks with in_vld = out_rdy = 1 -> 64 inputs and 64 outputs, in_rdy never 0, out_vld continuous after the first block.
REQ-034 SHALL verify backpressure fill: out_rdy = 0 throughout and 40 vectors offered -> exactly 32 accepted; in_rdy = 0 from the cycle after the 32nd accept; out_data stable at bank 0 row 0.
REQ-035 SHALL verify randomised handshake: vld and rdy toggled in random bursts of 7-13 cycles on and 7-13 off over 8 blocks -> every output matches the software transpose; no loss or duplication.
REQ-036 SHALL verify signed extremes: elements 0x7FF and 0x800 (EW = 12) alternating -> values preserved bit-exact after transpose.
REQ-037 SHALL verify reset mid-operation: rst pulsed after 20 accepts and 5 outputs -> out_vld = 0, in_rdy = 1 immediately; a subsequent block transposes correctly.

Source files
------------

// File: rtl/col_transpose_buf.sv
// Ping-pong column transpose buffer: N column vectors are written into one bank
// while the other bank is read back row by row, producing the transposed block.
module col_transpose_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic [(DATA_WIDTH+4)*N-1:0]     in_data,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [(DATA_WIDTH+4)*N-1:0]     out_data
);

  localparam int EW = DATA_WIDTH + 4;
  localparam int AW = $clog2(N);

  // Handshake: a transfer happens on a rising clk edge where vld and rdy are
  // both 1; vld/data are held while vld=1 and rdy=0. Both rdy and vld outputs
  // here come from registered state only.

  logic [1:0]    full_q, full_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [AW-1:0] wc_q, wc_d;
  logic [AW-1:0] rc_q, rc_d;

  // Storage indexed [bank][vector][element]; not reset, contents are only
  // observed once the bank's full flag is set.
  logic [EW-1:0] mem_q [2][N][N];

  logic in_acc;
  logic out_acc;

  assign in_rdy  = ~full_q[wb_q];
  assign out_vld = full_q[rb_q];
  assign in_acc  = in_vld & in_rdy;
  assign out_acc = out_vld & out_rdy;

  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wc_d   = wc_q;
    rc_d   = rc_q;
    // wb and rb never point at the same bank when both edges fire, so the
    // set and the clear below never collide.
    if (in_acc) begin
      wc_d = wc_q + AW'(1);
      if (wc_q == AW'(N - 1)) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    if (out_acc) begin
      rc_d = rc_q + AW'(1);
      if (rc_q == AW'(N - 1)) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 2'b00;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wc_q   <= '0;
      rc_q   <= '0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wc_q   <= wc_d;
      rc_q   <= rc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_acc) begin
      for (int j = 0; j < N; j++) begin
        mem_q[wb_q][wc_q][j] <= in_data[EW*j +: EW];
      end
    end
  end

  // Output row rc: element i is element rc of stored vector i.
  always_comb begin
    out_data = '0;
    if (out_vld) begin
      for (int i = 0; i < N; i++) begin
        out_data[EW*i +: EW] = mem_q[rb_q][i][rc_q];
      end
    end
  end

endmodule

// File: tb/tb_col_transpose_buf.sv
// Bench for col_transpose_buf: randomized and directed vectors, a transpose
// reference model feeding an expected queue, and an output monitor.
module tb_col_transpose_buf;

  localparam int DATA_WIDTH = 8;
  localparam int N          = 16;
  localparam int EW         = DATA_WIDTH + 4;
  localparam int W          = EW * N;

  logic         clk;
  logic         rst;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_data;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_data;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_blk[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic         held;
  logic [W-1:0] held_data;
  logic         fi, fo;

  col_transpose_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: collect N accepted columns, emit the N rows of the transpose.
  function automatic void model_push(input logic [W-1:0] d);
    logic [W-1:0] t;
    logic [W-1:0] col;
    cur_blk.push_back(d);
    if (cur_blk.size() == N) begin
      for (int r = 0; r < N; r++) begin
        t = '0;
        for (int i = 0; i < N; i++) begin
          col = cur_blk[i];
          t[EW*i +: EW] = col[EW*r +: EW];
        end
        exp_q.push_back(t);
      end
      cur_blk.delete();
    end
  endfunction

  function automatic void model_reset();
    cur_blk.delete();
    exp_q.delete();
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int j = 0; j < N; j++) v[EW*j +: EW] = EW'($urandom_range(0, (1 << EW) - 1));
    return v;
  endfunction

  function automatic logic [W-1:0] ramp_vec(input int v);
    logic [W-1:0] d;
    for (int k = 0; k < N; k++) d[EW*k +: EW] = EW'(16 * v + k);
    return d;
  endfunction

  function automatic logic [W-1:0] ext_vec(input int v);
    logic [W-1:0] d;
    for (int k = 0; k < N; k++) d[EW*k +: EW] = ((v + k) % 2 == 1) ? 12'h800 : 12'h7FF;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                       output logic f_in, output logic f_out);
    @(negedge clk);
    in_vld  = v;
    in_data = d;
    out_rdy = r;
    #1;
    f_in  = in_vld && in_rdy;
    f_out = out_vld && out_rdy;
    if (f_in) model_push(d);
  endtask

  task automatic drain(input string nm);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) cycle(1'b0, '0, 1'b1, fi, fo);
    check(nm, W'(exp_q.size()), '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_vld", W'(out_vld), W'(1));
        check("hold_data", out_data, held_data);
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_data, 'x);
        end else begin
          check("row_data", out_data, exp_q.pop_front());
        end
      end else if (!out_vld) begin
        check("idle_zero", out_data, '0);
      end
      held      = out_vld && !out_rdy;
      held_data = out_data;
    end
  end

  // ---------------- tests ----------------
  initial begin
    int acc, outs, errs, gaps, lows;
    logic started, von, ron;
    int vcnt, rcnt;

    rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0; held = 1'b0;
    held_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_rdy", W'(in_rdy), W'(1));
    check("rst_out_vld", W'(out_vld), W'(0));
    check("rst_out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b0;

    // Single block, element k of vector v = 16*v+k.
    acc = 0;
    for (int v = 0; v < N; v++) begin
      cycle(1'b1, ramp_vec(v), 1'b1, fi, fo);
      if (fi) acc++;
    end
    check("single_accepts", W'(acc), W'(N));
    check("single_vld_early", W'(out_vld), W'(0));
    cycle(1'b0, '0, 1'b1, fi, fo);
    check("single_vld_latency", W'(out_vld), W'(1));
    check("single_row0_elem1", W'(out_data[EW +: EW]), W'(16));
    drain("single_drain");

    // Back-to-back blocks.
    acc = 0; outs = 0; gaps = 0; lows = 0; started = 1'b0;
    for (int c = 0; c < 300 && outs < 4 * N; c++) begin
      cycle(acc < 4 * N, rand_vec(), 1'b1, fi, fo);
      if (acc < 4 * N && !in_rdy) lows++;
      if (fi) acc++;
      if (fo) outs++;
      if (out_vld) started = 1'b1;
      else if (started && outs < 4 * N) gaps++;
    end
    check("b2b_accepts", W'(acc), W'(4 * N));
    check("b2b_outputs", W'(outs), W'(4 * N));
    check("b2b_in_rdy_low", W'(lows), '0);
    check("b2b_out_gaps", W'(gaps), '0);
    drain("b2b_drain");

    // Backpressure fill: nothing leaves, two banks fill.
    acc = 0; errs = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, rand_vec(), 1'b0, fi, fo);
      if (in_rdy != (c < 2 * N)) errs++;
      if (fi) acc++;
    end
    check("bp_accepts", W'(acc), W'(2 * N));
    check("bp_in_rdy_profile", W'(errs), '0);
    check("bp_out_vld", W'(out_vld), W'(1));
    if (exp_q.size() > 0) check("bp_row0", out_data, exp_q[0]);
    else check("bp_row0_missing", W'(exp_q.size()), W'(2 * N));
    outs = 0; errs = 0;
    for (int c = 0; c < 100 && outs < 2 * N; c++) begin
      cycle(1'b0, '0, 1'b1, fi, fo);
      if (in_rdy != (outs >= N)) errs++;
      if (fo) outs++;
    end
    check("bp_drain_outputs", W'(outs), W'(2 * N));
    check("bp_in_rdy_reassert", W'(errs), '0);
    drain("bp_drain");

    // Randomised bursts over 8 blocks.
    acc = 0; outs = 0; von = 1'b0; ron = 1'b0; vcnt = 0; rcnt = 0;
    for (int c = 0; c < 6000 && (acc < 8 * N || exp_q.size() > 0); c++) begin
      if (vcnt == 0) begin von = ~von; vcnt = $urandom_range(7, 13); end
      if (rcnt == 0) begin ron = ~ron; rcnt = $urandom_range(7, 13); end
      vcnt--; rcnt--;
      cycle(von && acc < 8 * N, rand_vec(), ron, fi, fo);
      if (fi) acc++;
      if (fo) outs++;
    end
    check("rand_accepts", W'(acc), W'(8 * N));
    check("rand_outputs", W'(outs), W'(8 * N));
    drain("rand_drain");

    // Signed extremes.
    for (int v = 0; v < N; v++) cycle(1'b1, ext_vec(v), 1'b1, fi, fo);
    drain("ext_drain");

    // Reset mid-operation after 20 accepts and 5 outputs.
    acc = 0; outs = 0;
    for (int c = 0; c < 100 && outs < 5; c++) begin
      cycle(acc < 20, rand_vec(), 1'b1, fi, fo);
      if (fi) acc++;
      if (fo) outs++;
    end
    check("mid_accepts", W'(acc), W'(20));
    @(negedge clk);
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out_vld", W'(out_vld), W'(0));
    check("mid_rst_in_rdy", W'(in_rdy), W'(1));
    check("mid_rst_out_data", out_data, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < N; v++) cycle(1'b1, rand_vec(), 1'b1, fi, fo);
    cycle(1'b0, '0, 1'b1, fi, fo);
    check("post_rst_vld", W'(out_vld), W'(1));
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
